// File: rtl/mul8_arbiter_pkg.sv
// Shared definitions for the two-port mul8 arbiter: FSM encoding and default latency.
`timescale 1ns/1ps
package mul8_arbiter_pkg;

  localparam int MUL_LAT_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mul8_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: on a tie, the port that did not win last time is granted.
`timescale 1ns/1ps
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       en_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    if (en_i) begin
      if (req_i == 2'b11) begin
        grant_o = last_i ? 2'b01 : 2'b10;
      end else begin
        grant_o = req_i;
      end
    end
  end

endmodule

// File: rtl/mul8_arbiter.sv
// Shares one external mul8 between two requesters: round-robin accept, S sequencing,
// fixed-latency wait, product capture and a one-cycle response pulse to the winner.
`timescale 1ns/1ps
module mul8_arbiter
  import mul8_arbiter_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  output logic        req0_ready,
  output logic        rsp0_valid,
  output logic [15:0] rsp0_p,
  input  logic        req1_valid,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  output logic        req1_ready,
  output logic        rsp1_valid,
  output logic [15:0] rsp1_p,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  output logic        mul_s,
  input  logic [15:0] mul_p,
  output logic        busy
);

  state_e             state_q, state_d;
  logic               ptr_q, ptr_d;
  logic               owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         mul_a_q, mul_a_d;
  logic [7:0]         mul_b_q, mul_b_d;
  logic               mul_s_q, mul_s_d;
  logic               rsp0_valid_q, rsp0_valid_d;
  logic               rsp1_valid_q, rsp1_valid_d;
  logic [15:0]        rsp0_p_q, rsp0_p_d;
  logic [15:0]        rsp1_p_q, rsp1_p_d;
  logic [1:0]         grant;

  // Ready must be low while reset is held, so the arbiter is disabled by rst too.
  rr_arb2 u_arb (
    .req_i   ({req1_valid, req0_valid}),
    .last_i  (ptr_q),
    .en_i    ((state_q == IDLE) && !rst),
    .grant_o (grant)
  );

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    mul_s_d      = mul_s_q;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    rsp0_p_d     = rsp0_p_q;
    rsp1_p_d     = rsp1_p_q;
    case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          owner_d = grant[1];
          ptr_d   = grant[1];
          mul_a_d = grant[1] ? req1_a : req0_a;
          mul_b_d = grant[1] ? req1_b : req0_b;
          mul_s_d = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        mul_s_d = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (cnt_q == CNT_W'(MUL_LAT - 1)) begin
          if (owner_q) begin
            rsp1_p_d     = mul_p;
            rsp1_valid_d = 1'b1;
          end else begin
            rsp0_p_d     = mul_p;
            rsp0_valid_d = 1'b1;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b1;
      owner_q      <= 1'b0;
      cnt_q        <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      mul_s_q      <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_p_q     <= '0;
      rsp1_p_q     <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      mul_s_q      <= mul_s_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_p_q     <= rsp0_p_d;
      rsp1_p_q     <= rsp1_p_d;
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_p     = rsp0_p_q;
  assign rsp1_p     = rsp1_p_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign mul_s      = mul_s_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mul8_arbiter.sv
// Scoreboard bench for mul8_arbiter with a behavioural fixed-latency mul8 attached.
`timescale 1ns/1ps
module tb_mul8_arbiter;

  localparam int LAT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid;
  logic [15:0] rsp0_p, rsp1_p;
  logic [7:0]  mul_a, mul_b;
  logic        mul_s;
  logic [15:0] mul_p;
  logic        busy;

  typedef struct {
    int          port;
    logic [15:0] p;
    int          hs;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   grant_q[$];
  int   hs_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   cyc = 0;
  int   rsp_cnt0 = 0;
  int   rsp_cnt1 = 0;
  int   s_run = 0;

  mul8_arbiter #(.MUL_LAT(LAT), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .rsp0_valid (rsp0_valid),
    .rsp0_p     (rsp0_p),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_p     (rsp1_p),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_s      (mul_s),
    .mul_p      (mul_p),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // mul8 model: P is only meaningful once S has been high for LAT cycles.
  always @(posedge clk) s_run <= mul_s ? s_run + 1 : 0;
  assign mul_p = (mul_s && s_run >= LAT - 1) ? ({8'h00, mul_a} * {8'h00, mul_b}) : 16'hDEAD;

  task automatic chk(input string tag, input longint got, input longint exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (req0_ready || req1_ready) begin
        chk("ready_while_busy", longint'(busy), 0);
        chk("ready_onehot", longint'(req0_ready && req1_ready), 0);
      end
      if (rsp0_valid || rsp1_valid) begin
        if (rsp0_valid) rsp_cnt0++;
        if (rsp1_valid) rsp_cnt1++;
        if (sb_q.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("rsp_both", longint'(rsp0_valid && rsp1_valid), 0);
          chk("rsp_port", rsp1_valid ? 1 : 0, mon_e.port);
          chk("rsp_p", mon_e.port == 1 ? rsp1_p : rsp0_p, mon_e.p);
          chk("latency", cyc - mon_e.hs, LAT + 2);
        end
      end
    end
  end

  task automatic send(input int port, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    bit   done = 1'b0;
    if (port == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b;
    end
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if ((port == 0 && req0_ready) || (port == 1 && req1_ready)) begin
        e.port = port;
        e.p    = {8'h00, a} * {8'h00, b};
        e.hs   = cyc;
        sb_q.push_back(e);
        grant_q.push_back(port);
        hs_q.push_back(cyc);
        done = 1'b1;
      end
    end
    if (!done) chk("handshake_timeout", 0, 1);
    @(posedge clk); #1;
    if (port == 0) req0_valid = 1'b0;
    else           req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !busy) done = 1'b1;
    end
    if (!done) chk("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    sb_q.delete();
    grant_q.delete();
    hs_q.delete();
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req0_valid = 1'b1; req0_a = 8'd0; req0_b = 8'd0;
    req1_valid = 1'b0; req1_a = 8'd0; req1_b = 8'd0;
    @(negedge clk);
    chk("ready_in_rst", longint'(req0_ready), 0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst = 1'b0;
    chk("rst_busy", longint'(busy), 0);
    chk("rst_mul_s", longint'(mul_s), 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    chk("rst_rsp_valid", longint'(rsp0_valid | rsp1_valid), 0);
    chk("rst_rsp0_p", rsp0_p, 0);
    chk("rst_rsp1_p", rsp1_p, 0);

    // single request on port 0
    send(0, 8'd8, 8'd2);
    chk("load_mul_s", longint'(mul_s), 0);
    chk("load_busy", longint'(busy), 1);
    chk("load_mul_a", mul_a, 8);
    chk("load_mul_b", mul_b, 2);
    @(posedge clk); #1;
    chk("run_mul_s", longint'(mul_s), 1);
    wait_idle();
    chk("t1_rsp1_cnt", rsp_cnt1, 0);
    chk("t1_rsp0_cnt", rsp_cnt0, 1);

    // port 1 alone
    send(1, 8'd20, 8'd5);
    wait_idle();
    chk("rsp0_p_hold", rsp0_p, 16);
    chk("rsp1_p_hold", rsp1_p, 100);
    chk("idle_mul_s", longint'(mul_s), 1);
    chk("idle_mul_a", mul_a, 20);

    // simultaneous after reset: port 0 first, port 1 the cycle after DONE
    do_reset(1);
    fork
      send(0, 8'd3, 8'd4);
      send(1, 8'd255, 8'd255);
    join
    wait_idle();
    chk("tie_grants", grant_q.size(), 2);
    if (grant_q.size() == 2) begin
      chk("tie_first", grant_q[0], 0);
      chk("tie_second", grant_q[1], 1);
      chk("b2b_gap", hs_q[1] - hs_q[0], LAT + 3);
    end

    // fairness with both ports continuously valid
    grant_q.delete();
    hs_q.delete();
    rsp_cnt0 = 0;
    rsp_cnt1 = 0;
    fork
      begin send(0, 8'd11, 8'd13); send(0, 8'd17, 8'd19); end
      begin send(1, 8'd23, 8'd29); send(1, 8'd31, 8'd37); end
    join
    wait_idle();
    chk("fair_grants", grant_q.size(), 4);
    for (int i = 0; i < grant_q.size() && i < 4; i++) begin
      chk($sformatf("fair_grant%0d", i), grant_q[i], i % 2);
    end
    chk("fair_rsp0_cnt", rsp_cnt0, 2);
    chk("fair_rsp1_cnt", rsp_cnt1, 2);

    // reset mid-RUN at cnt=3: result discarded, pointer back to 1
    send(0, 8'd10, 8'd10);
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_busy", longint'(busy), 1);
    do_reset(1);
    chk("post_rst_busy", longint'(busy), 0);
    chk("post_rst_mul_s", longint'(mul_s), 0);
    chk("post_rst_rsp0_p", rsp0_p, 0);
    repeat (LAT + 4) @(posedge clk);
    #1;
    fork
      send(0, 8'd0, 8'd200);
      send(1, 8'd7, 8'd9);
    join
    wait_idle();
    chk("rst_ptr_first", grant_q.size() > 0 ? grant_q[0] : -1, 0);
    chk("rsp1_63", rsp1_p, 63);
    chk("rsp0_zero", rsp0_p, 0);

    // upper operand boundary
    send(1, 8'd1, 8'd255);
    wait_idle();
    chk("rsp1_255", rsp1_p, 255);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mul8_arbiter.md
Name: mul8_arbiter

Overview:
- Shares a single mul8 multiplier between two independent requesters (port 0 and port 1).
- Accepts an operand pair over a valid/ready handshake, using round-robin priority.
- Sequences the multiplier's S control (low-then-high start), waits a fixed latency, captures P, and returns it to the winning requester as a one-cycle response pulse.
- Sits between the client logic and one mul8 instance; mul8 itself is instantiated outside this block.

Parameters:
- MUL_LAT, 8: cycles mul_s must stay high before mul_p is valid (≥1).
- CNT_W, 4: width of the latency counter; must satisfy 2^CNT_W > MUL_LAT.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  port 0 has an operand pair.
- req0_a  in  8  port 0 multiplicand.
- req0_b  in  8  port 0 multiplier.
- req0_ready  out  1  port 0 accepted this cycle (valid & ready = handshake).
- rsp0_valid  out  1  one-cycle pulse: rsp0_p holds the port 0 product.
- rsp0_p  out  16  port 0 product.
- req1_valid, req1_a, req1_b, req1_ready, rsp1_valid, rsp1_p: same as port 0, for port 1.
- mul_a  out  8  to mul8 A.
- mul_b  out  8  to mul8 B.
- mul_s  out  1  to mul8 S.
- mul_p  in  16  from mul8 P.
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- FSM states: IDLE, LOAD, RUN, DONE.
- Reset: state=IDLE, last-grant pointer=1 (port 0 wins the first tie), mul_a=0, mul_b=0, mul_s=0, rsp*_valid=0, rsp*_p=0, cnt=0, busy=0.
- reqN_ready is combinational, asserted only in IDLE and only for the granted port; 0 in all other states and while rst=1.
- Grant rule in IDLE:
  - Only one valid: grant it.
  - Both valid: grant the port that is not the last-grant pointer.
- Handshake at cycle t (IDLE, grant g):
  - Latch operands into mul_a/mul_b; record owner=g; pointer←g.
  - Go to LOAD.
- LOAD (cycle t+1):
  - mul_s=0; mul_a/mul_b stable.
  - cnt←0; go to RUN.
- RUN (cycles t+2 .. t+1+MUL_LAT):
  - mul_s=1; cnt increments each cycle.
  - When cnt reaches MUL_LAT-1, capture mul_p into rsp_owner_p and go to DONE.
- DONE (cycle t+2+MUL_LAT):
  - rsp_owner_valid=1 for exactly this cycle.
  - The other port's rsp_valid stays 0.
  - Go to IDLE.
- Latency: handshake to response pulse = MUL_LAT+2 cycles.
- Throughput: one product per MUL_LAT+3 cycles when back-to-back.
- rspN_p holds its last captured value until that port's next capture; it is not cleared in IDLE.
- mul_s stays 1 after RUN, through DONE and IDLE, until the next LOAD drives it low.
- mul_a/mul_b hold their last operands until the next handshake.
- Requests arriving during LOAD, RUN or DONE are not accepted; requesters must hold valid and operands until ready.
- No backpressure on responses; a requester that misses the pulse loses the result.
- Reset mid-operation (any state):
  - Return to the reset values on the next edge.
  - The in-flight result is discarded; no rsp pulse.
  - Pointer returns to 1.
- Arithmetic: unsigned 8×8→16; the block does not alter mul_p.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, LOAD=2'd1, RUN=2'd2, DONE=2'd3) and the default MUL_LAT.
- One sub-module: rr_arb2.
  - Inputs: req[1:0], last-grant pointer, enable.
  - Outputs: one-hot grant[1:0].
  - Purely combinational.
- Everything else (FSM, counter, capture registers) stays in mul8_arbiter.

Test Plan:
- Single request: req0 A=8'd8, B=8'd2 → req0_ready at handshake, mul_s low for one cycle then high, rsp0_valid pulse MUL_LAT+2 cycles later with rsp0_p=16'd16; rsp1_valid stays 0.
- Port 1 alone: A=8'd20, B=8'd5 → rsp1_p=16'd100; rsp0_p unchanged.
- Simultaneous requests after reset: req0 (3×4), req1 (255×255) both held valid.
  - Port 0 is served first: rsp0_p=12.
  - Port 1 is served next: rsp1_p=16'd65025.
  - Second handshake occurs the cycle after the DONE pulse.
- Fairness: both ports continuously valid for 4 transactions → grants alternate 0,1,0,1; each port gets exactly 2 responses.
- Reset mid-RUN: assert rst for 1 cycle at cnt=3 → next cycle busy=0, mul_s=0, no rsp pulse; a following req1 (7×9) returns 63 with normal latency.
- Zero/boundary operands: 0×200 → 0; 1×255 → 255; ready is never asserted while busy=1.
